// File: rtl/ook_rx_demod_if.sv
// Byte-side and sample-side signals of the OOK receive demodulator.
// The slave modport is the demodulator; the master modport is whatever feeds it samples.
interface ook_rx_demod_if;
   logic [7:0] adcdata;
   logic [7:0] dataout;
   logic       rdsig;
   logic       frameerror;
   logic       busy;
   logic       bit_dbg;

   modport master (
      output adcdata,
      input  dataout, rdsig, frameerror, busy, bit_dbg
   );

   modport slave (
      input  adcdata,
      output dataout, rdsig, frameerror, busy, bit_dbg
   );
endinterface

// File: rtl/ook_rx_demod.sv
// OOK receiver: integrates carrier magnitude over fixed bit windows and frames the
// hard decisions into start / 8 data (MSB first) / stop bytes with a one-cycle strobe.
module ook_rx_demod #(
   parameter int unsigned SPB         = 7172,
   parameter int unsigned ACC_W       = 20,
   parameter int unsigned THRESH      = 229504,
   parameter int unsigned START_LEVEL = 48
) (
   input  logic          clk,
   input  logic          reset,
   ook_rx_demod_if.slave bus
);

   localparam int unsigned      CNT_W    = $clog2(SPB);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPB - 1);
   localparam logic [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);
   localparam logic [7:0]       START_V  = 8'(START_LEVEL);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_RESYNC
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [ACC_W-1:0] acc, acc_nxt;
   logic [ACC_W-1:0] sum;
   logic [2:0]       bitcnt, bitcnt_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic [7:0]       dataout_q, dataout_nxt;
   logic             rdsig_q, rdsig_nxt;
   logic             ferr_q, ferr_nxt;
   logic             dbg_q, dbg_nxt;
   logic [7:0]       mag;
   logic             win_end;
   logic             decision;

   // Offset-binary distance from mid-scale; 0x00 maps to 128, which still fits 8 bits.
   assign mag      = bus.adcdata[7] ? (bus.adcdata - 8'd128) : (8'd128 - bus.adcdata);
   assign sum      = acc + ACC_W'(mag);
   assign win_end  = (cnt == CNT_LAST);
   assign decision = (sum >= THRESH_V);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_nxt   = state;
      cnt_nxt     = cnt;
      acc_nxt     = acc;
      bitcnt_nxt  = bitcnt;
      shreg_nxt   = shreg;
      dataout_nxt = dataout_q;
      rdsig_nxt   = 1'b0;
      ferr_nxt    = 1'b0;
      dbg_nxt     = dbg_q;

      if (state != S_IDLE) begin
         if (win_end) begin
            cnt_nxt = '0;
            acc_nxt = '0;
            dbg_nxt = decision;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
            acc_nxt = sum;
         end
      end

      unique case (state)
         S_IDLE: begin
            // The arming sample already counts as sample 0 of the start window.
            if (mag >= START_V) begin
               acc_nxt   = ACC_W'(mag);
               cnt_nxt   = CNT_W'(1);
               state_nxt = S_START;
            end
         end
         S_START: begin
            if (win_end) begin
               bitcnt_nxt = '0;
               state_nxt  = decision ? S_DATA : S_IDLE;
            end
         end
         S_DATA: begin
            if (win_end) begin
               shreg_nxt  = {shreg[6:0], decision};
               bitcnt_nxt = bitcnt + 3'd1;
               if (bitcnt == 3'd7) state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (win_end) begin
               if (decision) begin
                  ferr_nxt  = 1'b1;
                  state_nxt = S_RESYNC;
               end else begin
                  dataout_nxt = shreg;
                  rdsig_nxt   = 1'b1;
                  state_nxt   = S_IDLE;
               end
            end
         end
         S_RESYNC: begin
            if (win_end && !decision) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         acc       <= '0;
         bitcnt    <= '0;
         shreg     <= '0;
         dataout_q <= '0;
         rdsig_q   <= 1'b0;
         ferr_q    <= 1'b0;
         dbg_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         acc       <= acc_nxt;
         bitcnt    <= bitcnt_nxt;
         shreg     <= shreg_nxt;
         dataout_q <= dataout_nxt;
         rdsig_q   <= rdsig_nxt;
         ferr_q    <= ferr_nxt;
         dbg_q     <= dbg_nxt;
      end
   end

   assign bus.dataout    = dataout_q;
   assign bus.rdsig      = rdsig_q;
   assign bus.frameerror = ferr_q;
   assign bus.busy       = (state != S_IDLE);
   assign bus.bit_dbg    = dbg_q;

endmodule
